cmach_recp_ram: RTL and testbench
=================================

CMACH_RECP_RAM -- requirements
Module: cmach_recp_ram

Interface
REQ-001 SHALL have parameter NUM_DRINKS, default 5, giving the number of drink types.
REQ-002 SHALL have parameter NUM_SIZES, default 3, giving the number of cup sizes per drink.
REQ-003 SHALL have parameter TIME_W, default 4, giving the width of each timing field.
REQ-004 SHALL have port clk  input  1  as its single clock.
REQ-005 SHALL have port rst_n  input  1  as its reset: asynchronous assert, active-low.
REQ-006 SHALL have port restore_req  input  1  to request a reload of the default recipes.
REQ-007 SHALL have port busy  output  1  that is high while the table is being (re)loaded.
REQ-008 SHALL have port rd_req  input  1  as its read strobe.
REQ-009 SHALL have ports rd_drink  input  $clog2(NUM_DRINKS)  and rd_size  input  $clog2(NUM_SIZES)  as the read index.
REQ-010 SHALL have ports rd_valid  output  1, rd_recipe  output  ENTRY_W  and rd_err  output  1  as the read response.
REQ-011 SHALL have ports wr_valid  input  1  and wr_ready  output  1  as the write handshake.
REQ-012 SHALL have ports wr_drink, wr_size (widths as REQ-009) and wr_recipe  input  ENTRY_W  as the write payload.

Function
REQ-013 SHALL use entry width ENTRY_W = 3 + 4*TIME_W, with fields {load_filter, high_press, pour_time, hot_water_time, grinder_time, cocoa_time, add_creamer}, MSB first.
REQ-014 SHALL use flat index idx = drink*NUM_SIZES + size, with depth N = NUM_DRINKS*NUM_SIZES.
REQ-015 SHALL implement an FSM with states INIT, IDLE and RESTORE, where INIT and RESTORE write default entry k at step k, one entry per cycle, k = 0..N-1, and then go to IDLE.
REQ-016 SHALL enter INIT on reset release and enter RESTORE from IDLE when restore_req=1, with restore_req ignored in INIT and RESTORE.
REQ-017 SHALL drive busy=1 and wr_ready=0 in INIT and RESTORE, and busy=0 and wr_ready=1 in IDLE.
REQ-018 SHALL accept a write when wr_valid && wr_ready, with the entry updated at that clock edge.
REQ-019 SHALL drop an accepted write whose index is out of range without any side effect.
REQ-020 SHALL give priority to restore_req over a write accepted in the same IDLE cycle, so that the write is dropped.
REQ-021 SHALL return every read with 1-cycle latency: rd_valid=1 in the cycle after rd_req=1, and the reads are fully pipelined (back-to-back rd_req each receive a response).
REQ-022 SHALL, when a read and a write target the same index in the same cycle, return the old value.
REQ-023 SHALL respond to a read with rd_err=1 and rd_recipe=0 when the index is out of range or the read is issued while busy=1.
REQ-024 SHALL hold rd_recipe stable and keep rd_err=0 whenever rd_valid=0.
REQ-025 SHALL take default entries from the package table when (d,s) is within the standard 5x3 table, zero-extended to TIME_W when TIME_W>4 and truncated to TIME_W when TIME_W<4, and SHALL use all-zero defaults elsewhere.

Reset
REQ-026 SHALL, while rst_n=0, drive busy=1, wr_ready=0, rd_valid=0, rd_err=0, rd_recipe=0, set the FSM state to INIT and the step counter to 0.
REQ-027 SHALL abort an in-progress RESTORE on reset assertion and restart from step 0 in INIT.
REQ-028 SHALL not require the table storage itself to be reset, because INIT rewrites every entry.

Configuration
REQ-029 SHALL, with CMACH_RECP_PARITY_EN defined, store one even-parity bit per entry.
REQ-030 SHALL, with that macro defined, recompute parity on every read and drive rd_err=1 on a mismatch while still returning the stored data.
REQ-031 SHALL, with that macro defined, add a 1-bit input port par_inj that inverts the stored parity bit of the entry being written.
REQ-032 SHALL, with CMACH_RECP_PARITY_EN undefined, have no par_inj port and no parity storage.

Structure
REQ-033 SHALL define in package cmach_recp_pkg: coffee_recipe_t parametrised by TIME_W, the drink and size enumerations, the 5x3 default table, and the function default_recipe(d,s).
REQ-034 SHALL place the storage array and its read and write ports in sub-module cmach_recp_mem (depth N, width ENTRY_W, plus 1 bit when the parity macro is defined).

Verification
REQ-035 SHALL cover: reset release -> busy=1 for exactly 15 cycles, then wr_ready=1.
REQ-036 SHALL cover: read drink 0 size 1 -> next cycle rd_valid=1, rd_err=0, fields 0,1,6,3,4,3,0.
REQ-037 SHALL cover: write drink 1 size 2 with pour_time 9 while reading the same index in the same cycle -> old pour_time 8 is returned, and the next read returns 9.
REQ-038 SHALL cover: restore_req after the write of REQ-037 -> busy=1 for 15 cycles, then drink 1 size 2 reads pour_time 8; a wr_valid in the restore_req cycle is dropped.
REQ-039 SHALL cover: a read of drink 5, and a read issued during INIT -> rd_valid=1, rd_err=1, rd_recipe=0.
REQ-040 SHALL cover, with CMACH_RECP_PARITY_EN defined: a write with par_inj=1 to drink 4 size 0, then a read of that entry -> rd_err=1 with the written data returned.

Source files
------------

// File: rtl/cmach_recp_pkg.sv
// Coffee machine recipe table: shared types, FSM states and the standard default recipes.
// Optional feature macro used by the RAM: CMACH_RECP_PARITY_EN (per-entry even parity).
package cmach_recp_pkg;

  // Timing field width of the standard table; the RAM resizes to its own TIME_W.
  localparam int unsigned RECP_TIME_W = 4;
  localparam int unsigned STD_DRINKS  = 5;
  localparam int unsigned STD_SIZES   = 3;

  typedef enum logic [2:0] {
    DrinkEspresso, DrinkAmericano, DrinkLatte, DrinkCappuccino, DrinkMocha
  } drink_e;

  typedef enum logic [1:0] {SizeSmall, SizeMedium, SizeLarge} size_e;

  typedef enum logic [1:0] {StInit, StIdle, StRestore} state_e;

  // MSB first, matches the packed RAM entry layout.
  typedef struct packed {
    logic                   load_filter;
    logic                   high_press;
    logic [RECP_TIME_W-1:0] pour_time;
    logic [RECP_TIME_W-1:0] hot_water_time;
    logic [RECP_TIME_W-1:0] grinder_time;
    logic [RECP_TIME_W-1:0] cocoa_time;
    logic                   add_creamer;
  } coffee_recipe_t;

  localparam coffee_recipe_t DEFAULT_TABLE [0:STD_DRINKS-1][0:STD_SIZES-1] = '{
    '{ '{1'b0, 1'b1, 4'd5, 4'd2,  4'd3, 4'd2,  1'b0},
       '{1'b0, 1'b1, 4'd6, 4'd3,  4'd4, 4'd3,  1'b0},
       '{1'b0, 1'b1, 4'd7, 4'd4,  4'd5, 4'd4,  1'b0} },
    '{ '{1'b1, 1'b0, 4'd6, 4'd5,  4'd2, 4'd0,  1'b0},
       '{1'b1, 1'b0, 4'd7, 4'd6,  4'd3, 4'd0,  1'b0},
       '{1'b1, 1'b0, 4'd8, 4'd7,  4'd4, 4'd0,  1'b0} },
    '{ '{1'b1, 1'b1, 4'd3, 4'd6,  4'd2, 4'd0,  1'b1},
       '{1'b1, 1'b1, 4'd4, 4'd8,  4'd3, 4'd0,  1'b1},
       '{1'b1, 1'b1, 4'd5, 4'd10, 4'd4, 4'd0,  1'b1} },
    '{ '{1'b0, 1'b1, 4'd3, 4'd4,  4'd2, 4'd1,  1'b1},
       '{1'b0, 1'b1, 4'd4, 4'd5,  4'd3, 4'd1,  1'b1},
       '{1'b0, 1'b1, 4'd5, 4'd6,  4'd4, 4'd2,  1'b1} },
    '{ '{1'b1, 1'b0, 4'd4, 4'd6,  4'd2, 4'd7,  1'b1},
       '{1'b1, 1'b0, 4'd5, 4'd8,  4'd3, 4'd9,  1'b1},
       '{1'b1, 1'b0, 4'd6, 4'd12, 4'd4, 4'd11, 1'b1} }
  };

  // Recipes outside the standard 5x3 table default to all-zero.
  function automatic coffee_recipe_t default_recipe(input int unsigned d, input int unsigned s);
    if (d < STD_DRINKS && s < STD_SIZES) begin
      return DEFAULT_TABLE[3'(d)][2'(s)];
    end
    return '0;
  endfunction

endpackage

// File: rtl/cmach_recp_mem.sv
// Recipe storage array: one synchronous write port, one combinational read port, no reset
// (the table is fully rewritten after every reset release).
module cmach_recp_mem
  import cmach_recp_pkg::*;
#(
  parameter int unsigned DEPTH  = 15,
  parameter int unsigned WIDTH  = 19,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port; the caller only asserts i_we for in-range addresses.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Out-of-range reads return zero rather than an undefined element.
  assign o_rdata = ({1'b0, i_raddr} < (ADDR_W + 1)'(DEPTH)) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/cmach_recp_ram.sv
// Coffee machine recipe RAM: loads the default table after reset or on restore_req, serves
// 1-cycle pipelined reads and ready/valid writes.
// Optional macro CMACH_RECP_PARITY_EN adds per-entry even parity and the par_inj input.
module cmach_recp_ram
  import cmach_recp_pkg::*;
#(
  parameter int unsigned NUM_DRINKS = 5,
  parameter int unsigned NUM_SIZES  = 3,
  parameter int unsigned TIME_W     = 4,
  localparam int unsigned ENTRY_W   = 3 + 4 * TIME_W,
  localparam int unsigned DRINK_W   = (NUM_DRINKS > 1) ? $clog2(NUM_DRINKS) : 1,
  localparam int unsigned SIZE_W    = (NUM_SIZES > 1) ? $clog2(NUM_SIZES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restore_req,
  output logic               busy,
  input  logic               rd_req,
  input  logic [DRINK_W-1:0] rd_drink,
  input  logic [SIZE_W-1:0]  rd_size,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_recipe,
  output logic               rd_err,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DRINK_W-1:0] wr_drink,
  input  logic [SIZE_W-1:0]  wr_size,
  input  logic [ENTRY_W-1:0] wr_recipe
`ifdef CMACH_RECP_PARITY_EN
  ,
  input  logic               par_inj
`endif
);

  localparam int unsigned DEPTH = NUM_DRINKS * NUM_SIZES;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef CMACH_RECP_PARITY_EN
  localparam int unsigned MEM_W = ENTRY_W + 1;
`else
  localparam int unsigned MEM_W = ENTRY_W;
`endif

  function automatic logic [IDX_W-1:0] flat_idx(input logic [DRINK_W-1:0] d,
                                                input logic [SIZE_W-1:0]  s);
    int unsigned v;
    v = 32'(d) * NUM_SIZES + 32'(s);
    return IDX_W'(v);
  endfunction

  function automatic logic in_range(input logic [DRINK_W-1:0] d, input logic [SIZE_W-1:0] s);
    return (32'(d) < NUM_DRINKS) && (32'(s) < NUM_SIZES);
  endfunction

  // Size casts zero-extend or truncate the standard 4-bit timings to TIME_W.
  function automatic logic [ENTRY_W-1:0] pack_entry(input coffee_recipe_t r);
    return {r.load_filter, r.high_press, TIME_W'(r.pour_time), TIME_W'(r.hot_water_time),
            TIME_W'(r.grinder_time), TIME_W'(r.cocoa_time), r.add_creamer};
  endfunction

  state_e             r_state;
  logic [IDX_W-1:0]   r_step;
  logic [DRINK_W-1:0] r_init_d;
  logic [SIZE_W-1:0]  r_init_s;
  logic               r_busy;
  logic               r_wr_ready;
  logic               r_rd_valid;
  logic               r_rd_err;
  logic [ENTRY_W-1:0] r_rd_recipe;

  logic [ENTRY_W-1:0] w_def_entry;
  logic [MEM_W-1:0]   w_def_word;
  logic [MEM_W-1:0]   w_wr_word;
  logic [MEM_W-1:0]   w_rd_word;
  logic               w_rd_par_err;
  logic               w_wr_fire;
  logic               w_mem_we;
  logic [IDX_W-1:0]   w_mem_waddr;
  logic [MEM_W-1:0]   w_mem_wdata;
  logic [IDX_W-1:0]   w_rd_idx;
  logic               w_rd_in_range;

  assign w_def_entry   = pack_entry(default_recipe(32'(r_init_d), 32'(r_init_s)));
  assign w_rd_idx      = flat_idx(rd_drink, rd_size);
  assign w_rd_in_range = in_range(rd_drink, rd_size);

`ifdef CMACH_RECP_PARITY_EN
  // Stored bit makes the total even; par_inj deliberately corrupts it on external writes.
  assign w_def_word   = {^w_def_entry, w_def_entry};
  assign w_wr_word    = {(^wr_recipe) ^ par_inj, wr_recipe};
  assign w_rd_par_err = ^w_rd_word;
`else
  assign w_def_word   = w_def_entry;
  assign w_wr_word    = wr_recipe;
  assign w_rd_par_err = 1'b0;
`endif

  // Write port arbitration: table loading owns the port while busy; restore_req drops writes.
  always_comb begin
    w_wr_fire   = wr_valid && r_wr_ready && !restore_req && in_range(wr_drink, wr_size);
    w_mem_we    = 1'b0;
    w_mem_waddr = r_step;
    w_mem_wdata = w_def_word;
    if (r_state != StIdle) begin
      w_mem_we = 1'b1;
    end else if (w_wr_fire) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = flat_idx(wr_drink, wr_size);
      w_mem_wdata = w_wr_word;
    end
  end

  // Control FSM with registered busy/wr_ready; loads one default entry per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StInit;
      r_step     <= '0;
      r_init_d   <= '0;
      r_init_s   <= '0;
      r_busy     <= 1'b1;
      r_wr_ready <= 1'b0;
    end else begin
      unique case (r_state)
        StInit, StRestore: begin
          if (r_step == IDX_W'(DEPTH - 1)) begin
            r_state    <= StIdle;
            r_step     <= '0;
            r_init_d   <= '0;
            r_init_s   <= '0;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end else begin
            r_step <= r_step + IDX_W'(1);
            if (r_init_s == SIZE_W'(NUM_SIZES - 1)) begin
              r_init_s <= '0;
              r_init_d <= r_init_d + DRINK_W'(1);
            end else begin
              r_init_s <= r_init_s + SIZE_W'(1);
            end
          end
        end
        StIdle: begin
          if (restore_req) begin
            r_state    <= StRestore;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  // Read response register; recipe holds its value between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid  <= 1'b0;
      r_rd_err    <= 1'b0;
      r_rd_recipe <= '0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        if (r_busy || !w_rd_in_range) begin
          r_rd_err    <= 1'b1;
          r_rd_recipe <= '0;
        end else begin
          r_rd_err    <= w_rd_par_err;
          r_rd_recipe <= w_rd_word[ENTRY_W-1:0];
        end
      end else begin
        r_rd_err <= 1'b0;
      end
    end
  end

  cmach_recp_mem #(
    .DEPTH (DEPTH),
    .WIDTH (MEM_W),
    .ADDR_W(IDX_W)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_mem_we),
    .i_waddr(w_mem_waddr),
    .i_wdata(w_mem_wdata),
    .i_raddr(w_rd_idx),
    .o_rdata(w_rd_word)
  );

  assign busy      = r_busy;
  assign wr_ready  = r_wr_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_err    = r_rd_err;
  assign rd_recipe = r_rd_recipe;

endmodule

// File: tb/tb_cmach_recp_ram.sv
// Scoreboard bench for cmach_recp_ram: directed cases plus randomized traffic against a
// behavioural table model.
module tb_cmach_recp_ram;

  localparam int unsigned ND = 5;
  localparam int unsigned NS = 3;
  localparam int unsigned TW = 4;
  localparam int unsigned EW = 3 + 4 * TW;
  localparam int unsigned N  = ND * NS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          restore_req = 1'b0;
  logic          busy;
  logic          rd_req = 1'b0;
  logic [2:0]    rd_drink = '0;
  logic [1:0]    rd_size = '0;
  logic          rd_valid;
  logic [EW-1:0] rd_recipe;
  logic          rd_err;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [2:0]    wr_drink = '0;
  logic [1:0]    wr_size = '0;
  logic [EW-1:0] wr_recipe = '0;
`ifdef CMACH_RECP_PARITY_EN
  logic          par_inj = 1'b0;
`endif

  always #5 clk = ~clk;

  cmach_recp_ram #(
    .NUM_DRINKS(ND),
    .NUM_SIZES (NS),
    .TIME_W    (TW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restore_req(restore_req),
    .busy       (busy),
    .rd_req     (rd_req),
    .rd_drink   (rd_drink),
    .rd_size    (rd_size),
    .rd_valid   (rd_valid),
    .rd_recipe  (rd_recipe),
    .rd_err     (rd_err),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_drink   (wr_drink),
    .wr_size    (wr_size),
    .wr_recipe  (wr_recipe)
`ifdef CMACH_RECP_PARITY_EN
    ,
    .par_inj    (par_inj)
`endif
  );

  typedef struct {
    int          cyc;
    bit          err;
    logic [EW-1:0] rec;
  } exp_t;

  exp_t          q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  logic [EW-1:0] model [N];
  bit            par_bad [N];
  int            busy_cnt = 0;
  bit            obs_busy;
  logic [EW-1:0] last_rec = '0;

  // Stimulus for the next cycle; cleared after every tick.
  bit            s_rd, s_wr, s_restore, s_inj;
  int            s_rd_d, s_rd_s, s_wr_d, s_wr_s;
  logic [EW-1:0] s_wr_data;

  function automatic logic [EW-1:0] mk(input bit lf, input bit hp, input bit [3:0] p,
                                       input bit [3:0] hw, input bit [3:0] g,
                                       input bit [3:0] c, input bit cr);
    return {lf, hp, p, hw, g, c, cr};
  endfunction

  // Standard recipe table: load_filter, high_press, pour, hot_water, grinder, cocoa, creamer.
  function automatic logic [EW-1:0] def_entry(input int k);
    case (k)
      0:  return mk(0, 1, 5, 2, 3, 2, 0);
      1:  return mk(0, 1, 6, 3, 4, 3, 0);
      2:  return mk(0, 1, 7, 4, 5, 4, 0);
      3:  return mk(1, 0, 6, 5, 2, 0, 0);
      4:  return mk(1, 0, 7, 6, 3, 0, 0);
      5:  return mk(1, 0, 8, 7, 4, 0, 0);
      6:  return mk(1, 1, 3, 6, 2, 0, 1);
      7:  return mk(1, 1, 4, 8, 3, 0, 1);
      8:  return mk(1, 1, 5, 10, 4, 0, 1);
      9:  return mk(0, 1, 3, 4, 2, 1, 1);
      10: return mk(0, 1, 4, 5, 3, 1, 1);
      11: return mk(0, 1, 5, 6, 4, 2, 1);
      12: return mk(1, 0, 4, 6, 2, 7, 1);
      13: return mk(1, 0, 5, 8, 3, 9, 1);
      14: return mk(1, 0, 6, 12, 4, 11, 1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [EW-1:0] with_pour(input logic [EW-1:0] e, input bit [3:0] p);
    logic [EW-1:0] r;
    r = e;
    r[16:13] = p;
    return r;
  endfunction

  task automatic load_defaults();
    for (int k = 0; k < N; k++) begin
      model[k]   = def_entry(k);
      par_bad[k] = 1'b0;
    end
  endtask

  task automatic clear_stim();
    s_rd = 0; s_wr = 0; s_restore = 0; s_inj = 0;
    s_rd_d = 0; s_rd_s = 0; s_wr_d = 0; s_wr_s = 0; s_wr_data = '0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every response, checks idle behaviour otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_rec = '0;
    end else if (rd_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: rd_valid=1 with nothing outstanding at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || rd_err !== e.err || rd_recipe !== e.rec) begin
          n_bad++;
          $display("FAIL rd_resp: got cyc=%0d err=%b rec=%h, expected cyc=%0d err=%b rec=%h",
                   cyc, rd_err, rd_recipe, e.cyc, e.err, e.rec);
        end
      end
      last_rec = rd_recipe;
    end else begin
      n_cmp++;
      if (rd_err !== 1'b0 || rd_recipe !== last_rec) begin
        n_bad++;
        $display("FAIL rd_idle: got err=%b rec=%h, expected err=0 rec=%h",
                 rd_err, rd_recipe, last_rec);
      end
    end
  end

  // One clock cycle: drive stimulus, queue the expected read, check handshake, update model.
  task automatic tick();
    bit   busy_m;
    int   ri, wi;
    exp_t e;
    rd_req      = s_rd;
    rd_drink    = 3'(s_rd_d);
    rd_size     = 2'(s_rd_s);
    wr_valid    = s_wr;
    wr_drink    = 3'(s_wr_d);
    wr_size     = 2'(s_wr_s);
    wr_recipe   = s_wr_data;
    restore_req = s_restore;
`ifdef CMACH_RECP_PARITY_EN
    par_inj     = s_inj;
`endif
    busy_m = (busy_cnt > 0);
    if (s_rd) begin
      e.cyc = cyc + 1;
      if (busy_m || s_rd_d >= ND || s_rd_s >= NS) begin
        e.err = 1'b1;
        e.rec = '0;
      end else begin
        ri    = s_rd_d * NS + s_rd_s;
        e.err = par_bad[ri];
        e.rec = model[ri];
      end
      q.push_back(e);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== busy_m || wr_ready !== !busy_m) begin
      n_bad++;
      $display("FAIL handshake: got busy=%b wr_ready=%b, expected busy=%b wr_ready=%b",
               busy, wr_ready, busy_m, !busy_m);
    end
    obs_busy = busy;
    if (busy_m) begin
      busy_cnt--;
    end else if (s_restore) begin
      busy_cnt = N;
      load_defaults();
    end else if (s_wr && s_wr_d < ND && s_wr_s < NS) begin
      wi          = s_wr_d * NS + s_wr_s;
      model[wi]   = s_wr_data;
      par_bad[wi] = s_inj;
    end
    @(posedge clk);
    #1;
    clear_stim();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_stim();
    rd_req = 0; wr_valid = 0; restore_req = 0;
    q.delete();
    #1;
    n_cmp++;
    if (busy !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_err !== 1'b0 ||
        rd_recipe !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b wr_ready=%b rd_valid=%b rd_err=%b rec=%h, expected 1 0 0 0 0",
               busy, wr_ready, rd_valid, rd_err, rd_recipe);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    busy_cnt = N;
    load_defaults();
  endtask

  // Counts observed busy cycles until the table is ready again (bounded).
  task automatic measure_busy(input string name);
    int n;
    n = 0;
    do begin
      tick();
      if (obs_busy) n++;
    end while (obs_busy && n < 100);
    n_cmp++;
    if (n != N) begin
      n_bad++;
      $display("FAIL %s: busy lasted %0d cycles, expected %0d", name, n, N);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stim();
    @(posedge clk);
    #1;
    apply_reset();

    // Read issued during INIT, then the loading period itself.
    s_rd = 1; s_rd_d = 0; s_rd_s = 1;
    measure_busy("init_busy_len");

    // Default entry read.
    s_rd = 1; s_rd_d = 0; s_rd_s = 1;
    tick();

    // Same-cycle write and read of one index returns the old value; next read the new one.
    s_wr = 1; s_wr_d = 1; s_wr_s = 2; s_wr_data = with_pour(def_entry(5), 4'd9);
    s_rd = 1; s_rd_d = 1; s_rd_s = 2;
    tick();
    s_rd = 1; s_rd_d = 1; s_rd_s = 2;
    tick();

    // Restore wins over a write in the same cycle.
    s_restore = 1;
    s_wr = 1; s_wr_d = 1; s_wr_s = 2; s_wr_data = with_pour(def_entry(5), 4'd12);
    tick();
    measure_busy("restore_busy_len");
    s_rd = 1; s_rd_d = 1; s_rd_s = 2;
    tick();

    // Out-of-range reads and writes.
    s_rd = 1; s_rd_d = 5; s_rd_s = 0;
    tick();
    s_rd = 1; s_rd_d = 0; s_rd_s = 3;
    s_wr = 1; s_wr_d = 6; s_wr_s = 1; s_wr_data = '1;
    tick();

`ifdef CMACH_RECP_PARITY_EN
    s_wr = 1; s_wr_d = 4; s_wr_s = 0; s_wr_data = EW'($urandom); s_inj = 1;
    tick();
    s_rd = 1; s_rd_d = 4; s_rd_s = 0;
    tick();
    s_wr = 1; s_wr_d = 4; s_wr_s = 0; s_wr_data = EW'($urandom);
    tick();
    s_rd = 1; s_rd_d = 4; s_rd_s = 0;
    tick();
`endif

    // Randomized traffic, including out-of-range indices and occasional restores.
    for (int i = 0; i < 400; i++) begin
      s_rd      = ($urandom_range(0, 2) != 0);
      s_rd_d    = $urandom_range(0, 7);
      s_rd_s    = $urandom_range(0, 3);
      s_wr      = ($urandom_range(0, 1) != 0);
      s_wr_d    = $urandom_range(0, 7);
      s_wr_s    = $urandom_range(0, 3);
      s_wr_data = EW'($urandom);
      s_restore = ($urandom_range(0, 59) == 0);
`ifdef CMACH_RECP_PARITY_EN
      s_inj     = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    while (busy_cnt > 0) tick();

    // Reset in the middle of a restore restarts loading from step 0.
    s_restore = 1;
    tick();
    repeat (5) tick();
    apply_reset();
    measure_busy("abort_busy_len");
    for (int k = 0; k < N; k++) begin
      s_rd = 1; s_rd_d = k / NS; s_rd_s = k % NS;
      tick();
    end

    repeat (3) tick();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL rd_missing: %0d responses outstanding, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
